uart_transmitter: RTL and testbench

Serial transmitter for the one-bit-per-clock UART link consumed by the existing receiver. It accepts bytes over a ready/valid-style handshake into a one-entry holding buffer, then emits a framing strobe, 8 data bits LSB first and one even-parity bit on TxD. It sits at the transmit end of the link, driving the receiver's RxD and RxD_data_ready inputs directly. It also provides a parity-error injection input for link verification.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_bit_timer.sv | 29 ++
 rtl/uart_transmitter.sv | 150 +++++++++++++++
 tb/tb_uart_transmitter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the one-bit-per-clock UART link: byte width, transmit
// FSM states and the parity helper.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        GAP
    } tx_state_t;

    // Even parity: the returned bit makes the XOR over data plus parity zero.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: bit_done pulses on the last cycle of every CLKS_PER_BIT
// window and the count is held at zero while clear is asserted.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic Clk,
    input  logic Rst,
    input  logic clear,
    output logic bit_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign bit_done = ~clear && (cnt == LAST);

    always_ff @(posedge Clk) begin
        if (Rst || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: one-entry holding buffer feeding a framing FSM that sends a
// strobe, 8 data bits LSB first, an even parity bit and an idle gap.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int GAP_CYCLES   = 1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 TxD_send,
    input  logic [DATA_BITS-1:0] TxD_data,
    input  logic                 Inject_parity_error,
    output logic                 TxD_ready,
    output logic                 TxD,
    output logic                 TxD_frame_start,
    output logic                 TxD_idle
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_t            state;
    logic                 buf_valid;
    logic [DATA_BITS-1:0] buf_data;
    logic                 buf_inj;
    logic [DATA_BITS-1:0] shifter;
    logic                 par_bit;
    logic [2:0]           bit_idx;
    logic [GW-1:0]        gap_cnt;

    logic timer_clear;
    logic bit_done;
    logic gap_done;
    logic frame_slot;
    logic launch;
    logic accept;
    logic going_idle;

    // frame_slot marks the edges where a new frame may begin: from IDLE, or
    // straight out of the last GAP cycle.
    assign gap_done    = (state == GAP) && (gap_cnt == GAP_LAST);
    assign frame_slot  = (state == IDLE) || gap_done;
    assign launch      = buf_valid && frame_slot;
    assign going_idle  = ~buf_valid && frame_slot;
    assign accept      = TxD_send && ~buf_valid;
    assign timer_clear = (state != DATA) && (state != PARITY);
    assign TxD_ready   = ~buf_valid;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .Clk     (Clk),
        .Rst     (Rst),
        .clear   (timer_clear),
        .bit_done(bit_done)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            buf_valid <= 1'b0;
        end else if (accept) begin
            buf_valid <= 1'b1;
        end else if (launch) begin
            buf_valid <= 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (accept) begin
            buf_data <= TxD_data;
            buf_inj  <= Inject_parity_error;
        end
    end

    // Parity is fixed at load time so the buffer is free for the next byte.
    always_ff @(posedge Clk) begin
        if (launch) begin
            shifter <= buf_data;
            par_bit <= even_parity(buf_data) ^ buf_inj;
        end else if ((state == DATA) && bit_done) begin
            shifter <= shifter >> 1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state           <= IDLE;
            TxD             <= 1'b1;
            TxD_frame_start <= 1'b0;
            TxD_idle        <= 1'b1;
            bit_idx         <= '0;
            gap_cnt         <= '0;
        end else begin
            TxD_frame_start <= 1'b0;
            TxD_idle        <= going_idle && ~accept;
            case (state)
                IDLE: begin
                    TxD <= 1'b1;
                    if (launch) begin
                        state           <= START;
                        TxD_frame_start <= 1'b1;
                    end
                end
                START: begin
                    state   <= DATA;
                    TxD     <= shifter[0];
                    bit_idx <= '0;
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_idx == LAST_BIT) begin
                            state <= PARITY;
                            TxD   <= par_bit;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            TxD     <= shifter[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        state   <= GAP;
                        TxD     <= 1'b1;
                        gap_cnt <= '0;
                    end
                end
                GAP: begin
                    TxD <= 1'b1;
                    if (gap_done) begin
                        if (launch) begin
                            state           <= START;
                            TxD_frame_start <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    TxD   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: a default-parameter instance decoded by a
// receiver model, and a slow instance checked cycle by cycle.
module tb_uart_transmitter;

    typedef struct {
        logic [7:0] data;
        logic       inj;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       send_a = 1'b0, inj_a = 1'b0;
    logic [7:0] data_a = 8'h00;
    logic       ready_a, txd_a, fs_a, idle_a;
    logic       send_b = 1'b0, inj_b = 1'b0;
    logic [7:0] data_b = 8'h00;
    logic       ready_b, txd_b, fs_b, idle_b;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    exp_t       aq[$];
    logic [1:0] bq[$];
    int         fs_times[$];
    int         amon = 0;
    logic [7:0] abits;
    logic       apar;
    exp_t       ae;
    logic       bactive = 1'b0;
    logic [1:0] bs;

    uart_transmitter dut_a (
        .Clk(clk), .Rst(rst), .TxD_send(send_a), .TxD_data(data_a),
        .Inject_parity_error(inj_a), .TxD_ready(ready_a), .TxD(txd_a),
        .TxD_frame_start(fs_a), .TxD_idle(idle_a)
    );

    uart_transmitter #(.CLKS_PER_BIT(3), .GAP_CYCLES(2)) dut_b (
        .Clk(clk), .Rst(rst), .TxD_send(send_b), .TxD_data(data_b),
        .Inject_parity_error(inj_b), .TxD_ready(ready_b), .TxD(txd_b),
        .TxD_frame_start(fs_b), .TxD_idle(idle_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Receiver model for the default instance: strobe, 8 bits LSB first, parity, gap.
    always @(negedge clk) begin
        if (rst) begin
            amon = 0;
            aq.delete();
        end else if (amon == 0) begin
            if (fs_a) begin
                amon = 1;
                fs_times.push_back(cyc);
            end
        end else begin
            if (amon <= 8) begin
                abits = {txd_a, abits[7:1]};
            end else if (amon == 9) begin
                apar = txd_a;
            end else begin
                vectors++;
                if (txd_a !== 1'b1) begin
                    miscompares++;
                    $display("FAIL gap_level: TxD=%b required 1", txd_a);
                end
                if (aq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_frame: got %02h required none", abits);
                end else begin
                    ae = aq.pop_front();
                    vectors++;
                    if (abits !== ae.data) begin
                        miscompares++;
                        $display("FAIL rx_data: got %02h required %02h", abits, ae.data);
                    end
                    vectors++;
                    if (apar !== ((^ae.data) ^ ae.inj)) begin
                        miscompares++;
                        $display("FAIL parity_bit(%02h): got %b required %b", ae.data, apar,
                                 (^ae.data) ^ ae.inj);
                    end
                    vectors++;
                    if (((^abits) ^ apar) !== ae.inj) begin
                        miscompares++;
                        $display("FAIL rx_error(%02h): got %b required %b", ae.data,
                                 (^abits) ^ apar, ae.inj);
                    end
                end
            end
            amon = (amon == 10) ? 0 : amon + 1;
        end
    end

    // Slow instance: every frame cycle compared against the pushed {strobe, TxD} pattern.
    always @(negedge clk) begin
        if (rst) begin
            bactive = 1'b0;
            bq.delete();
        end else begin
            if (!bactive && fs_b && bq.size() > 0) bactive = 1'b1;
            if (bactive) begin
                bs = bq.pop_front();
                vectors++;
                if ({fs_b, txd_b} !== bs) begin
                    miscompares++;
                    $display("FAIL slow_frame at cycle %0d: {strobe,TxD}=%b required %b",
                             cyc, {fs_b, txd_b}, bs);
                end
                if (bq.size() == 0) bactive = 1'b0;
            end
        end
    end

    task automatic send_a_byte(input logic [7:0] b, input logic inj);
        int   t;
        logic r;
        t = 0;
        send_a = 1'b1;
        data_a = b;
        inj_a  = inj;
        forever begin
            r = ready_a;
            @(posedge clk);
            #1;
            if (r) begin
                aq.push_back('{data: b, inj: inj});
                break;
            end
            t++;
            if (t > 100) begin
                vectors++;
                miscompares++;
                $display("FAIL send_a_timeout: ready=%b required 1", ready_a);
                break;
            end
        end
        send_a = 1'b0;
    endtask

    task automatic send_b_byte(input logic [7:0] b, input logic inj);
        int   t;
        logic r;
        t = 0;
        send_b = 1'b1;
        data_b = b;
        inj_b  = inj;
        forever begin
            r = ready_b;
            @(posedge clk);
            #1;
            if (r) begin
                bq.push_back(2'b11);
                for (int k = 0; k < 8; k++)
                    repeat (3) bq.push_back({1'b0, b[k]});
                repeat (3) bq.push_back({1'b0, (^b) ^ inj});
                repeat (2) bq.push_back(2'b01);
                break;
            end
            t++;
            if (t > 100) begin
                vectors++;
                miscompares++;
                $display("FAIL send_b_timeout: ready=%b required 1", ready_b);
                break;
            end
        end
        send_b = 1'b0;
    endtask

    task automatic wait_a_drain(input string name);
        int t;
        t = 0;
        while ((aq.size() != 0 || amon != 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (t >= 300) begin
            miscompares++;
            $display("FAIL %s_drain: %0d frames outstanding required 0", name, aq.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        vectors += 5;
        if (txd_a !== 1'b1) begin miscompares++; $display("FAIL reset_txd: got %b required 1", txd_a); end
        if (fs_a !== 1'b0) begin miscompares++; $display("FAIL reset_strobe: got %b required 0", fs_a); end
        if (idle_a !== 1'b1) begin miscompares++; $display("FAIL reset_idle: got %b required 1", idle_a); end
        if (ready_a !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b required 1", ready_a); end
        if ({txd_b, fs_b, idle_b, ready_b} !== 4'b1011) begin
            miscompares++;
            $display("FAIL reset_slow: got %b required 1011", {txd_b, fs_b, idle_b, ready_b});
        end
    endtask

    task automatic test_single_a5();
        send_a_byte(8'hA5, 1'b0);
        vectors += 2;
        if (ready_a !== 1'b0) begin miscompares++; $display("FAIL a5_ready_full: got %b required 0", ready_a); end
        if (fs_a !== 1'b0) begin miscompares++; $display("FAIL a5_early_strobe: got %b required 0", fs_a); end
        @(posedge clk);
        #1;
        vectors += 3;
        if (fs_a !== 1'b1) begin miscompares++; $display("FAIL a5_strobe: got %b required 1", fs_a); end
        if (txd_a !== 1'b1) begin miscompares++; $display("FAIL a5_strobe_txd: got %b required 1", txd_a); end
        if (ready_a !== 1'b1) begin miscompares++; $display("FAIL a5_ready_rise: got %b required 1", ready_a); end
        @(posedge clk);
        #1;
        vectors += 2;
        if (fs_a !== 1'b0) begin miscompares++; $display("FAIL a5_strobe_width: got %b required 0", fs_a); end
        if (txd_a !== 1'b1) begin miscompares++; $display("FAIL a5_bit0: got %b required 1", txd_a); end
        wait_a_drain("a5");
        repeat (2) @(posedge clk);
        #1;
        vectors += 2;
        if (idle_a !== 1'b1) begin miscompares++; $display("FAIL a5_idle_after: got %b required 1", idle_a); end
        if (txd_a !== 1'b1) begin miscompares++; $display("FAIL a5_txd_after: got %b required 1", txd_a); end
    endtask

    task automatic test_parity();
        send_a_byte(8'h01, 1'b0);
        wait_a_drain("par01");
        send_a_byte(8'h3C, 1'b1);
        wait_a_drain("inj3c");
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        logic       r;
        int         t;
        bytes[0] = 8'h11;
        bytes[1] = 8'h22;
        bytes[2] = 8'h33;
        fs_times.delete();
        send_a = 1'b1;
        inj_a  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_a = bytes[i];
            t = 0;
            forever begin
                r = ready_a;
                @(posedge clk);
                #1;
                if (r) break;
                t++;
                if (t > 100) break;
            end
            aq.push_back('{data: bytes[i], inj: 1'b0});
            vectors++;
            if (ready_a !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_ready_full[%0d]: got %b required 0", i, ready_a);
            end
        end
        send_a = 1'b0;
        wait_a_drain("b2b");
        vectors++;
        if (fs_times.size() != 3) begin
            miscompares++;
            $display("FAIL b2b_strobe_count: got %0d required 3", fs_times.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                vectors++;
                if (fs_times[i] - fs_times[i-1] != 11) begin
                    miscompares++;
                    $display("FAIL b2b_spacing[%0d]: got %0d required 11", i,
                             fs_times[i] - fs_times[i-1]);
                end
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_frame();
        int strobes;
        send_a_byte(8'hEF, 1'b0);
        send_a_byte(8'h5A, 1'b0);
        vectors++;
        if (ready_a !== 1'b0) begin miscompares++; $display("FAIL mid_buffered: ready=%b required 0", ready_a); end
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (txd_a !== 1'b0) begin miscompares++; $display("FAIL mid_bit4: got %b required 0", txd_a); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        vectors += 4;
        if (txd_a !== 1'b1) begin miscompares++; $display("FAIL mid_reset_txd: got %b required 1", txd_a); end
        if (ready_a !== 1'b1) begin miscompares++; $display("FAIL mid_reset_ready: got %b required 1", ready_a); end
        if (idle_a !== 1'b1) begin miscompares++; $display("FAIL mid_reset_idle: got %b required 1", idle_a); end
        if (fs_a !== 1'b0) begin miscompares++; $display("FAIL mid_reset_strobe: got %b required 0", fs_a); end
        strobes = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (fs_a) strobes++;
        end
        vectors++;
        if (strobes != 0) begin miscompares++; $display("FAIL mid_no_strobe: got %0d strobes required 0", strobes); end
    endtask

    task automatic test_slow_timing();
        int t;
        send_b_byte(8'hF0, 1'b0);
        send_b_byte(8'h0F, 1'b1);
        t = 0;
        while (bq.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (t >= 300) begin
            miscompares++;
            $display("FAIL slow_drain: %0d cycles outstanding required 0", bq.size());
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (idle_b !== 1'b1) begin miscompares++; $display("FAIL slow_idle_after: got %b required 1", idle_b); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_a5();
        test_parity();
        test_back_to_back();
        test_reset_mid_frame();
        test_slow_timing();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
